// File: rtl/seq_align_norm_shifter_if.sv
// Request/response bundle for the sequential align/normalize shifter.
interface seq_align_norm_shifter_if #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned CNT_W = 5
);
   logic             Start;
   logic [1:0]       Mode;
   logic [WIDTH-1:0] D;
   logic [CNT_W-1:0] Amt;
   logic [WIDTH-1:0] Q;
   logic             Sticky;
   logic [CNT_W-1:0] Count;
   logic             Busy;
   logic             Done;
   logic             Zero;

   modport master (
      output Start, Mode, D, Amt,
      input  Q, Sticky, Count, Busy, Done, Zero
   );

   modport slave (
      input  Start, Mode, D, Amt,
      output Q, Sticky, Count, Busy, Done, Zero
   );
endinterface

// File: rtl/seq_align_norm_shifter.sv
// One-bit-per-clock shifter: right-align with sticky, left shift, or left-normalize.
// Q/Sticky/Count/Zero hold between operations; Done pulses for one cycle.
module seq_align_norm_shifter #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned CNT_W = 5
) (
   input logic                      Clk,
   input logic                      Clear,
   seq_align_norm_shifter_if.slave  bus
);
   localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
   localparam logic [1:0] MODE_LOAD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_NORM  = 2'b11;

   typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;

   state_t           state_r, state_nxt;
   logic [WIDTH-1:0] q_r, q_nxt;
   logic             sticky_r, sticky_nxt;
   logic [CNT_W-1:0] count_r, count_nxt;
   logic [CNT_W-1:0] amt_r, amt_nxt;
   logic [1:0]       mode_r, mode_nxt;
   logic             busy_r, busy_nxt;
   logic             done_r, done_nxt;
   logic             zero_r, zero_nxt;
   logic [CNT_W-1:0] amt_clamp;
   logic             no_shift;
   logic             last_shift;

   assign amt_clamp = (bus.Amt > WIDTH_CNT) ? WIDTH_CNT : bus.Amt;

   // State and datapath registers
   always_ff @(posedge Clk or negedge Clear) begin
      if (!Clear) begin
         state_r  <= IDLE;
         q_r      <= '0;
         sticky_r <= 1'b0;
         count_r  <= '0;
         amt_r    <= '0;
         mode_r   <= MODE_LOAD;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         zero_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt;
         q_r      <= q_nxt;
         sticky_r <= sticky_nxt;
         count_r  <= count_nxt;
         amt_r    <= amt_nxt;
         mode_r   <= mode_nxt;
         busy_r   <= busy_nxt;
         done_r   <= done_nxt;
         zero_r   <= zero_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt  = state_r;
      q_nxt      = q_r;
      sticky_nxt = sticky_r;
      count_nxt  = count_r;
      amt_nxt    = amt_r;
      mode_nxt   = mode_r;
      zero_nxt   = zero_r;
      no_shift   = 1'b0;
      last_shift = 1'b0;

      case (state_r)
         IDLE: begin
            if (bus.Start) begin
               q_nxt      = bus.D;
               sticky_nxt = 1'b0;
               count_nxt  = '0;
               mode_nxt   = bus.Mode;
               amt_nxt    = amt_clamp;
               case (bus.Mode)
                  MODE_RIGHT, MODE_LEFT: no_shift = (amt_clamp == '0);
                  MODE_NORM:             no_shift = bus.D[WIDTH-1] | (bus.D == '0);
                  default:               no_shift = 1'b1;
               endcase
               state_nxt = no_shift ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            count_nxt = count_r + CNT_W'(1);
            case (mode_r)
               MODE_RIGHT: begin
                  q_nxt      = q_r >> 1;
                  sticky_nxt = sticky_r | q_r[0];
                  last_shift = (count_nxt == amt_r);
               end
               MODE_LEFT: begin
                  q_nxt      = q_r << 1;
                  last_shift = (count_nxt == amt_r);
               end
               default: begin
                  // Normalize stops once the MSB is set; a zero word never gets here.
                  q_nxt      = q_r << 1;
                  last_shift = q_nxt[WIDTH-1];
               end
            endcase
            if (last_shift) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (state_nxt == DONE) zero_nxt = (q_nxt == '0);
      busy_nxt = (state_nxt == SHIFT);
      done_nxt = (state_nxt == DONE);
   end

   assign bus.Q      = q_r;
   assign bus.Sticky = sticky_r;
   assign bus.Count  = count_r;
   assign bus.Busy   = busy_r;
   assign bus.Done   = done_r;
   assign bus.Zero   = zero_r;
endmodule
